mpu_sequencer: RTL
==================

# mpu_sequencer

Top-level sequencer for the `mpu` I2C master engine. It brings the engine out of reset, issues the one-shot init, then starts continuous register streaming. It assembles streamed bytes into fixed-size sensor frames and recovers from bus stalls with a watchdog-driven engine reset and re-init. It sits between the flight-control logic (frame consumer) and the `mpu` instance, which it owns exclusively.

## Interface
- `FRAME_BYTES`, 6 — bytes per output frame (1..16).
- `TIMEOUT_CYC`, 50000 — watchdog limit in clk cycles (1 ms at 50 MHz).
- `RST_CYC`, 16 — engine reset pulse width in clk cycles (≥2).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high = acquire, low = stop.
- `mpu_rst_n`  out  1  reset to engine, active-low.
- `mpu_init`  out  1  init request to engine.
- `mpu_transfer`  out  1  streaming request to engine.
- `init_done`  in  1  engine init-complete flag (sticky in the engine).
- `busy_now`  in  1  engine non-idle.
- `data_avalid`  in  1  engine byte strobe.
- `data`  in  8  engine byte.
- `frame_data`  out  8*FRAME_BYTES  last complete frame; the first byte received occupies the MSB byte.
- `frame_valid`  out  1  one-cycle pulse when `frame_data` updates.
- `frame_cnt`  out  16  completed frames, wraps.
- `err_cnt`  out  8  watchdog recoveries, saturates at 255.
- `seq_state`  out  3  current state encoding, for debug.

## Operation
- **States:**
  - IDLE=0
  - ENG_RST=1
  - INIT=2
  - WAIT_INIT=3
  - WAIT_IDLE=4
  - START_RD=5
  - STREAM=6
  - HALT=7
- **IDLE:** `mpu_rst_n`=0. `enable`=1 → ENG_RST.
- **ENG_RST:** `mpu_rst_n`=0 for RST_CYC cycles → INIT.
- **INIT:** `mpu_rst_n`=1, `mpu_init`=1 until `busy_now`=1 is sampled → WAIT_INIT.
- **WAIT_INIT:** wait for `init_done`=1 && `busy_now`=0 → WAIT_IDLE.
- **WAIT_IDLE:** wait for one cycle with `busy_now`=0 → START_RD.
- **START_RD:** `mpu_transfer`=1 until `busy_now`=1 is sampled → STREAM.
- **STREAM:**
  - Each rising edge of `data_avalid` (registered edge detect) shifts `data` into the frame shift register and increments the byte index.
  - When the index reaches FRAME_BYTES: copy the shift register to `frame_data`, pulse `frame_valid`, increment `frame_cnt`, reset the index to 0.
- **Watchdog:**
  - Counter is active in INIT, WAIT_INIT, START_RD and STREAM.
  - It is cleared on every state entry and on every `data_avalid` rising edge.
  - On reaching TIMEOUT_CYC: `err_cnt`+1 (saturating), discard the partial frame (index←0), → ENG_RST.
- **Disable:** `enable`=0 in any state other than IDLE/HALT → HALT.
  - HALT holds `mpu_rst_n`=0 for RST_CYC cycles → IDLE.
  - This takes priority over the watchdog and frame events in the same cycle.
  - A frame completing in that cycle is dropped.
- **Engine reset is mandatory.** Stopping or recovering always passes through a `mpu_rst_n` pulse, because the engine streams indefinitely once started.
- **`init_done` gating:** `init_done` is sticky in the engine. WAIT_INIT therefore also requires that `busy_now` was seen high in INIT; that condition is guaranteed by the INIT exit rule.

## Timing
- **Reset values:**
  - `mpu_rst_n`=0
  - `mpu_init`=0
  - `mpu_transfer`=0
  - `frame_data`=0
  - `frame_valid`=0
  - `frame_cnt`=0
  - `err_cnt`=0
  - `seq_state`=IDLE
  - Byte index = 0, watchdog = 0.
- All outputs are registered.
- `frame_valid` asserts 2 cycles after the `data_avalid` rising edge of the final byte: 1 cycle for the edge detect, 1 for the output register.
- `data` is sampled in the same cycle as the detected edge; it is stable for that cycle.
- `mpu_init`/`mpu_transfer` are levels held across multiple cycles. They drop the cycle after `busy_now`=1 is sampled.
- ENG_RST/HALT last exactly RST_CYC cycles. The count restarts on every entry.
- Async reset mid-stream: all state is cleared immediately and the engine is held in reset (`mpu_rst_n`=0) until `enable` restarts the sequence.
- `frame_cnt` wraps 0xFFFF→0. `err_cnt` sticks at 0xFF.

## Structure
- Package `mpu_seq_pkg`:
  - state encoding localparams (3-bit),
  - default FRAME_BYTES/TIMEOUT_CYC/RST_CYC constants,
  - `FRAME_W = 8*FRAME_BYTES`.
- One sub-module `mpu_frame_asm`: edge detect, shift register, byte index, frame commit, `frame_cnt`, with a synchronous flush input. The watchdog and FSM stay in the top.

## Test plan
- **Bring-up:** `enable`=1 with an engine model answering `busy_now` and `init_done` → `mpu_init` high until busy, then `mpu_transfer` high until busy, `seq_state` reaches 6.
- **Frame assembly:** stream bytes 0x11..0x66 with 1-cycle strobes → `frame_data`=0x112233445566, `frame_valid` one pulse 2 cycles after the 6th strobe, `frame_cnt`=1.
- **Wide strobe:** `data_avalid` held 5 cycles per byte → counted once per byte, still one frame per 6 bytes.
- **Stall:** stream 3 bytes then none for TIMEOUT_CYC → `err_cnt`=1, `mpu_rst_n` low 16 cycles, re-init. The next frame starts from the new first byte, not from the 4th.
- **Disable mid-frame:** `enable`=0 while the 6th byte edge is detected → no `frame_valid`, HALT then IDLE, `mpu_rst_n`=0 held.
- **Saturation/wrap:** force 300 timeouts → `err_cnt`=255. Run 65537 frames → `frame_cnt`=1.

Source files
------------

// File: rtl/mpu_seq_pkg.sv
// Shared definitions for the mpu sequencer: state encoding, default
// parameter values and the frame width helper.
package mpu_seq_pkg;

    // Sequencer states; the encoding is visible on the seq_state debug port.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENG_RST   = 3'd1,
        S_INIT      = 3'd2,
        S_WAIT_INIT = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_START_RD  = 3'd5,
        S_STREAM    = 3'd6,
        S_HALT      = 3'd7
    } seq_state_e;

    localparam int FRAME_BYTES_DEF = 6;
    localparam int TIMEOUT_CYC_DEF = 50000;  // 1 ms at 50 MHz
    localparam int RST_CYC_DEF     = 16;

    // Width in bits of a frame of n bytes.
    function automatic int frame_w(input int n);
        return 8 * n;
    endfunction

    localparam int FRAME_W_DEF = frame_w(FRAME_BYTES_DEF);

endpackage

// File: rtl/mpu_frame_asm.sv
// Frame assembler: detects rising edges of the engine byte strobe, shifts
// bytes into a frame register (first byte ends up in the MSB byte) and
// commits complete frames. A synchronous flush discards any partial frame
// and suppresses a commit in the same cycle.
module mpu_frame_asm
    import mpu_seq_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         data_avalid,
    input  logic [7:0]                   data,
    output logic                         byte_edge,
    output logic [8*FRAME_BYTES-1:0]     frame_data,
    output logic                         frame_valid,
    output logic [15:0]                  frame_cnt
);

    localparam int FRAME_W = frame_w(FRAME_BYTES);
    localparam int IDX_W   = $clog2(FRAME_BYTES + 1);

    logic               avalid_q, avalid_d;
    logic               edge_q, edge_d;
    logic [7:0]         byte_q, byte_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] shift_next;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_q, valid_d;
    logic [15:0]        cnt_q, cnt_d;

    // Edge detect, byte capture, shifting and frame commit.
    always_comb begin
        avalid_d   = data_avalid;
        edge_d     = data_avalid & ~avalid_q;
        byte_d     = edge_d ? data : byte_q;
        shift_next = (shift_q << 8) | FRAME_W'(byte_q);
        shift_d    = shift_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        valid_d    = 1'b0;
        cnt_d      = cnt_q;
        if (flush) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (edge_q) begin
            if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                frame_d = shift_next;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                shift_d = '0;
                idx_d   = '0;
            end else begin
                shift_d = shift_next;
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avalid_q <= 1'b0;
            edge_q   <= 1'b0;
            byte_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            avalid_q <= avalid_d;
            edge_q   <= edge_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign byte_edge   = edge_q;
    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: rtl/mpu_sequencer.sv
// Top-level sequencer for the mpu I2C engine: engine reset, one-shot init,
// continuous streaming, frame assembly and watchdog recovery. Every stop or
// recovery passes through an engine reset pulse because the engine keeps
// streaming once started.
module mpu_sequencer
    import mpu_seq_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int RST_CYC     = RST_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    output logic                     mpu_rst_n,
    output logic                     mpu_init,
    output logic                     mpu_transfer,
    input  logic                     init_done,
    input  logic                     busy_now,
    input  logic                     data_avalid,
    input  logic [7:0]               data,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    output logic [15:0]              frame_cnt,
    output logic [7:0]               err_cnt,
    output logic [2:0]               seq_state
);

    localparam int TMR_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(TMR_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       err_q, err_d;
    logic             rst_n_q, rst_n_d;
    logic             init_q, init_d;
    logic             xfer_q, xfer_d;
    logic             wd_active;
    logic             wd_expired;
    logic             rst_done;
    logic             byte_edge;
    logic             flush;

    // Next state, shared timer (reset pulse width / watchdog), error count
    // and registered engine controls. Disable wins over watchdog and frames.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wd_active  = (state_q == S_INIT) || (state_q == S_WAIT_INIT) ||
                     (state_q == S_START_RD) || (state_q == S_STREAM);
        wd_expired = wd_active && (timer_q == CNT_W'(TIMEOUT_CYC - 1));
        rst_done   = (timer_q == CNT_W'(RST_CYC - 1));

        if (!enable && (state_q != S_IDLE) && (state_q != S_HALT)) begin
            state_d = S_HALT;
        end else if (wd_expired) begin
            state_d = S_ENG_RST;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
            case (state_q)
                S_IDLE:      if (enable)                  state_d = S_ENG_RST;
                S_ENG_RST:   if (rst_done)                state_d = S_INIT;
                S_INIT:      if (busy_now)                state_d = S_WAIT_INIT;
                S_WAIT_INIT: if (init_done && !busy_now)  state_d = S_WAIT_IDLE;
                S_WAIT_IDLE: if (!busy_now)               state_d = S_START_RD;
                S_START_RD:  if (busy_now)                state_d = S_STREAM;
                S_STREAM:                                 state_d = S_STREAM;
                S_HALT:      if (rst_done)                state_d = S_IDLE;
                default:                                  state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (wd_active && byte_edge) begin
            timer_d = '0;
        end else if (wd_active || (state_q == S_ENG_RST) || (state_q == S_HALT)) begin
            timer_d = timer_q + CNT_W'(1);
        end else begin
            timer_d = '0;
        end

        rst_n_d = !((state_d == S_IDLE) || (state_d == S_ENG_RST) || (state_d == S_HALT));
        init_d  = (state_d == S_INIT);
        xfer_d  = (state_d == S_START_RD);
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            err_q   <= '0;
            rst_n_q <= 1'b0;
            init_q  <= 1'b0;
            xfer_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            rst_n_q <= rst_n_d;
            init_q  <= init_d;
            xfer_q  <= xfer_d;
        end
    end

    // Partial frames are dropped whenever streaming is not, or stops being, active.
    assign flush = (state_q != S_STREAM) || (state_d != S_STREAM);

    mpu_frame_asm #(
        .FRAME_BYTES (FRAME_BYTES)
    ) u_frame_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .data_avalid (data_avalid),
        .data        (data),
        .byte_edge   (byte_edge),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt)
    );

    assign mpu_rst_n    = rst_n_q;
    assign mpu_init     = init_q;
    assign mpu_transfer = xfer_q;
    assign err_cnt      = err_q;
    assign seq_state    = state_q;

endmodule
